// File: rtl/rr_stream_mux_if.sv
// Stream bundle between N input channels and one registered output port of the
// round-robin packet multiplexer. The mux takes the slave view, its environment the master view.
interface rr_stream_mux_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = (N > 2) ? $clog2(N) : 1;

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [SW-1:0]  out_sel;
  logic           out_valid;
  logic           out_ready;

  modport slave (
    input  in_data, in_last, in_valid, out_ready,
    output in_ready, out_data, out_last, out_sel, out_valid
  );

  modport master (
    output in_data, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_last, out_sel, out_valid
  );
endinterface

// File: rtl/rr_stream_mux.sv
// Packet-aware round-robin multiplexer: one channel owns the output until it sends
// its last beat, then arbitration restarts at the channel after it.
module rr_stream_mux #(
  parameter int N = 4,
  parameter int W = 8
) (
  input logic            clk,
  input logic            rst,
  rr_stream_mux_if.slave bus
);
  localparam int SW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] lockCh_q, lockCh_d;
  logic [W-1:0]  outData_q, outData_d;
  logic          outLast_q, outLast_d;
  logic [SW-1:0] outSel_q, outSel_d;
  logic          outValid_q, outValid_d;

  logic [SW-1:0] rrSel;
  logic [SW-1:0] sel;
  logic [W-1:0]  selData;
  logic          selLast;
  logic          selValid;
  logic          loadEn;
  logic          accept;

  function automatic logic [SW-1:0] wrapInc(input logic [SW-1:0] x);
    logic [SW-1:0] r;
    if (x == SW'(N - 1)) r = '0;
    else                 r = x + 1'b1;
    return r;
  endfunction

  // Modular add kept explicit so non-power-of-two N wraps at N, not 2**SW.
  function automatic logic [SW-1:0] wrapAdd(input logic [SW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N) sum = sum - N;
    return SW'(sum);
  endfunction

  // Walk from the farthest candidate to the nearest so the first valid after ptr wins.
  always_comb begin
    rrSel = ptr_q;
    for (int off = N - 1; off >= 0; off--) begin
      if (bus.in_valid[wrapAdd(ptr_q, off)]) rrSel = wrapAdd(ptr_q, off);
    end
  end

  assign sel = (state_q == LOCKED) ? lockCh_q : rrSel;

  always_comb begin
    selData  = '0;
    selLast  = 1'b0;
    selValid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i)) begin
        selData  = bus.in_data[i*W +: W];
        selLast  = bus.in_last[i];
        selValid = bus.in_valid[i];
      end
    end
  end

  assign loadEn = !outValid_q || bus.out_ready;
  assign accept = loadEn && selValid && !rst;

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < N; i++) begin
      bus.in_ready[i] = accept && (sel == SW'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lockCh_d   = lockCh_q;
    outData_d  = outData_q;
    outLast_d  = outLast_q;
    outSel_d   = outSel_q;
    outValid_d = outValid_q;

    if (accept) begin
      outData_d  = selData;
      outLast_d  = selLast;
      outSel_d   = sel;
      outValid_d = 1'b1;
    end else if (outValid_q && bus.out_ready) begin
      outValid_d = 1'b0;
    end

    if (accept) begin
      case (state_q)
        IDLE: begin
          if (selLast) begin
            ptr_d = wrapInc(sel);
          end else begin
            state_d  = LOCKED;
            lockCh_d = sel;
          end
        end
        LOCKED: begin
          if (selLast) begin
            state_d = IDLE;
            ptr_d   = wrapInc(lockCh_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      lockCh_q   <= '0;
      outData_q  <= '0;
      outLast_q  <= 1'b0;
      outSel_q   <= '0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lockCh_q   <= lockCh_d;
      outData_q  <= outData_d;
      outLast_q  <= outLast_d;
      outSel_q   <= outSel_d;
      outValid_q <= outValid_d;
    end
  end

  assign bus.out_data  = outData_q;
  assign bus.out_last  = outLast_q;
  assign bus.out_sel   = outSel_q;
  assign bus.out_valid = outValid_q;
endmodule

// File: doc/rr_stream_mux.md
RR_STREAM_MUX -- requirements
Module: rr_stream_mux

Interface
REQ-001 SHALL have parameter N, default 4, number of input channels (legal 2..8).
REQ-002 SHALL have parameter W, default 8, data width per channel in bits (legal 1..64).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_data, input, N*W, channel i data at bits [i*W +: W].
REQ-006 SHALL have port in_last, input, N, channel i marks final beat of a packet.
REQ-007 SHALL have port in_valid, input, N, channel i offers a beat.
REQ-008 SHALL have port in_ready, output, N, channel i beat accepted this cycle when in_valid[i] & in_ready[i].
REQ-009 SHALL have port out_data, output, W, registered output beat.
REQ-010 SHALL have port out_last, output, 1, registered last flag of the output beat.
REQ-011 SHALL have port out_sel, output, max(1,$clog2(N)), source channel index of the output beat.
REQ-012 SHALL have port out_valid, output, 1, output register holds a beat.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts; transfer when out_valid & out_ready.

Function
REQ-014 SHALL hold one beat in a single output register; load_en = !out_valid | out_ready.
REQ-015 SHALL assert at most one in_ready bit per cycle: in_ready[i] = load_en & in_valid[i] & (i == sel) & !rst.
REQ-016 SHALL, on a load, capture in_data/in_last of sel into out_data/out_last, sel into out_sel, and set out_valid=1.
REQ-017 SHALL clear out_valid when out_valid & out_ready and no new beat is loaded that cycle.
REQ-018 SHALL keep out_data, out_last, out_sel stable while out_valid & !out_ready.
REQ-019 SHALL sustain one beat per cycle when out_ready stays 1 (latency input-accept to out_valid: 1 cycle).
REQ-020 SHALL implement FSM states IDLE and LOCKED, plus a round-robin pointer ptr (0..N-1) and lock register lock_ch.
REQ-021 SHALL, in IDLE, set sel = first i with in_valid[i]=1 searching ptr, ptr+1, ... mod N; if no in_valid, no load and ptr unchanged.
REQ-022 SHALL, in IDLE, on accepting a beat with in_last=0, go LOCKED with lock_ch=sel.
REQ-023 SHALL, in IDLE, on accepting a beat with in_last=1, stay IDLE and set ptr=(sel+1) mod N.
REQ-024 SHALL, in LOCKED, set sel=lock_ch regardless of other channels' in_valid; no other channel sees in_ready=1.
REQ-025 SHALL, in LOCKED, on accepting a beat from lock_ch with in_last=1, go IDLE and set ptr=(lock_ch+1) mod N.
REQ-026 SHALL, in LOCKED with in_valid[lock_ch]=0, stall without changing state (no timeout).
REQ-027 SHALL wrap ptr from N-1 to 0, correct for non-power-of-two N.
REQ-028 SHALL treat a simultaneous downstream drain and upstream load in one cycle as a single replace, out_valid staying 1.

Reset
REQ-029 SHALL, when rst=1 at a clock edge, set out_valid=0, out_data=0, out_last=0, out_sel=0, ptr=0, lock_ch=0, state=IDLE.
REQ-030 SHALL drive in_ready=0 on all channels while rst=1.
REQ-031 SHALL, on reset mid-packet or with out_valid=1, discard the held beat and the lock with no further output from it.

Verification
REQ-032 SHALL cover: N=4,W=8, reset, all in_valid=1, in_last=1, out_ready=1 -> out_sel sequence 0,1,2,3,0,... one beat per cycle.
REQ-033 SHALL cover: ch1 sends 3-beat packet (last on 3rd) while ch0,ch2 valid -> out_sel 1,1,1 contiguous, then 2, then 0.
REQ-034 SHALL cover: out_valid=1, out_data=8'hA5, out_ready=0 for 5 cycles -> out_data/out_sel unchanged, in_ready=0 all.
REQ-035 SHALL cover: only ch3 valid, ptr=0 -> out_sel=3 next cycle; next arbitration starts at ptr=0 (wrap).
REQ-036 SHALL cover: rst=1 asserted mid-packet on ch2 -> next cycle out_valid=0, state IDLE, ch0 wins next (ptr=0).
REQ-037 SHALL cover: N=3 with all channels valid -> out_sel 0,1,2,0; checker compares against a behavioural model using === on every output.
